// File: rtl/ysyx_25040105_lsu_pkg.sv
// rtl/ysyx_25040105_lsu_pkg.sv - shared op encodings, FSM states and decode helpers for the LSU
// Purpose: op codes of the execute->LSU record, the 2-bit FSM state type,
//          and small decode helpers (load/store class, misalign, byte strobes).
// Ports:   none (package).
package ysyx_25040105_lsu_pkg;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LH   = 4'd2;
   localparam logic [3:0] OP_LW   = 4'd3;
   localparam logic [3:0] OP_LBU  = 4'd4;
   localparam logic [3:0] OP_LHU  = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Byte ops can never be misaligned; codes 9..15 behave as NONE.
   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU, OP_SH: return off[0];
         OP_LW, OP_SW:         return off != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] gen_wstrb(input logic [3:0] op, input logic [1:0] off);
      case (op)
         OP_SB:   return 4'b0001 << off;
         OP_SH:   return 4'b0011 << off;
         OP_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_25040105_lsu_if.sv
// rtl/ysyx_25040105_lsu_if.sv - execute-input, memory-bus and writeback-output signal bundle
// Purpose: groups the three LSU handshakes.
// Modports: slave  - the LSU itself (accepts records, drives the bus request and the writeback record)
//           master - the surrounding pipeline/memory (drives records, bus ready/response, out_ready)
interface ysyx_25040105_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_wdata;
   logic [DATA_W-1:0] in_alu_result;
   logic [4:0]        in_rd;
   logic [ADDR_W-1:0] in_pc;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_wen;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [3:0]        mem_req_wstrb;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;
   logic              mem_resp_err;

   logic              out_valid;
   logic              out_ready;
   logic [4:0]        out_rd;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_pc;
   logic              out_misalign;
   logic              out_err;

   modport slave (
      input  in_valid, in_op, in_addr, in_wdata, in_alu_result, in_rd, in_pc,
      output in_ready,
      output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
      output out_valid, out_rd, out_data, out_pc, out_misalign, out_err,
      input  out_ready
   );

   modport master (
      output in_valid, in_op, in_addr, in_wdata, in_alu_result, in_rd, in_pc,
      input  in_ready,
      input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
      input  out_valid, out_rd, out_data, out_pc, out_misalign, out_err,
      output out_ready
   );
endinterface

// File: rtl/ysyx_25040105_lsu_align.sv
// rtl/ysyx_25040105_lsu_align.sv - load lane extract/extend and store lane replication
// Purpose: purely combinational data steering between the 32-bit bus word and register values.
// Ports:   st_op_i/st_wdata_i -> st_wdata_o   store data replicated across byte lanes
//          ld_op_i/ld_off_i/ld_rdata_i -> ld_data_o   selected lane, sign- or zero-extended
module ysyx_25040105_lsu_align
   import ysyx_25040105_lsu_pkg::*;
(
   input  logic [3:0]  st_op_i,
   input  logic [31:0] st_wdata_i,
   output logic [31:0] st_wdata_o,
   input  logic [3:0]  ld_op_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);
   logic [31:0] shifted;

   assign shifted = ld_rdata_i >> {ld_off_i, 3'b000};

   always_comb begin
      case (ld_op_i)
         OP_LB:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
         OP_LH:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
         OP_LBU:  ld_data_o = {24'b0, shifted[7:0]};
         OP_LHU:  ld_data_o = {16'b0, shifted[15:0]};
         default: ld_data_o = shifted;   // LW is aligned, so shifted is the raw word
      endcase
   end

   // Replication lets the memory pick the right lane purely from wstrb.
   always_comb begin
      case (st_op_i)
         OP_SB:   st_wdata_o = {4{st_wdata_i[7:0]}};
         OP_SH:   st_wdata_o = {2{st_wdata_i[15:0]}};
         default: st_wdata_o = st_wdata_i;
      endcase
   end
endmodule

// File: rtl/ysyx_25040105_lsu.sv
// rtl/ysyx_25040105_lsu.sv - load/store unit between execute and writeback
// Purpose: accepts one execute record, performs at most one memory access and
//          emits one writeback record; IDLE -> REQ -> RESP -> OUT.
// Ports:   clk, rst_n (asynchronous, active-low)
//          bus (slave modport): in_* record input, mem_req_*/mem_resp_* bus, out_* writeback record
//          perf_load_cnt/perf_store_cnt/perf_stall_cnt only when YSYX_25040105_LSU_PERF_EN is defined
module ysyx_25040105_lsu
   import ysyx_25040105_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic rst_n,
   ysyx_25040105_lsu_if.slave bus
`ifdef YSYX_25040105_LSU_PERF_EN
   ,
   output logic [31:0] perf_load_cnt,
   output logic [31:0] perf_store_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);
   state_e            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [4:0]        rd_q, rd_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic [3:0]        req_wstrb_q, req_wstrb_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic              out_misalign_q, out_misalign_d;
   logic              out_err_q, out_err_d;

   logic [DATA_W-1:0] st_wdata;
   logic [DATA_W-1:0] ld_data;

   ysyx_25040105_lsu_align u_align (
      .st_op_i    (bus.in_op),
      .st_wdata_i (bus.in_wdata),
      .st_wdata_o (st_wdata),
      .ld_op_i    (op_q),
      .ld_off_i   (addr_q[1:0]),
      .ld_rdata_i (bus.mem_resp_data),
      .ld_data_o  (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         op_q           <= '0;
         addr_q         <= '0;
         pc_q           <= '0;
         rd_q           <= '0;
         req_wdata_q    <= '0;
         req_wstrb_q    <= '0;
         out_data_q     <= '0;
         out_rd_q       <= '0;
         out_misalign_q <= 1'b0;
         out_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         addr_q         <= addr_d;
         pc_q           <= pc_d;
         rd_q           <= rd_d;
         req_wdata_q    <= req_wdata_d;
         req_wstrb_q    <= req_wstrb_d;
         out_data_q     <= out_data_d;
         out_rd_q       <= out_rd_d;
         out_misalign_q <= out_misalign_d;
         out_err_q      <= out_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      addr_d         = addr_q;
      pc_d           = pc_q;
      rd_d           = rd_q;
      req_wdata_d    = req_wdata_q;
      req_wstrb_d    = req_wstrb_q;
      out_data_d     = out_data_q;
      out_rd_d       = out_rd_q;
      out_misalign_d = out_misalign_q;
      out_err_d      = out_err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               op_d           = bus.in_op;
               addr_d         = bus.in_addr;
               pc_d           = bus.in_pc;
               rd_d           = bus.in_rd;
               req_wdata_d    = st_wdata;
               req_wstrb_d    = gen_wstrb(bus.in_op, bus.in_addr[1:0]);
               out_misalign_d = 1'b0;
               out_err_d      = 1'b0;
               if (!is_load(bus.in_op) && !is_store(bus.in_op)) begin
                  out_data_d = bus.in_alu_result;
                  out_rd_d   = bus.in_rd;
                  state_d    = ST_OUT;
               end else if (is_misaligned(bus.in_op, bus.in_addr[1:0])) begin
                  out_misalign_d = 1'b1;
                  out_data_d     = '0;
                  out_rd_d       = '0;
                  state_d        = ST_OUT;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (bus.mem_req_ready) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.mem_resp_valid) begin
               state_d = ST_OUT;
               if (bus.mem_resp_err) begin
                  out_err_d  = 1'b1;
                  out_data_d = '0;
                  out_rd_d   = '0;
               end else if (is_store(op_q)) begin
                  out_data_d = '0;
                  out_rd_d   = '0;
               end else begin
                  out_data_d = ld_data;
                  out_rd_d   = rd_q;
               end
            end
         end
         ST_OUT: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready      = (state_q == ST_IDLE);
   assign bus.mem_req_valid = (state_q == ST_REQ);
   assign bus.mem_req_wen   = is_store(op_q);
   assign bus.mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.mem_req_wdata = req_wdata_q;
   assign bus.mem_req_wstrb = req_wstrb_q;
   assign bus.out_valid     = (state_q == ST_OUT);
   assign bus.out_rd        = out_rd_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_pc        = pc_q;
   assign bus.out_misalign  = out_misalign_q;
   assign bus.out_err       = out_err_q;

`ifdef YSYX_25040105_LSU_PERF_EN
   logic [31:0] load_cnt_q, store_cnt_q, stall_cnt_q;

   // Only accesses that reach RESP without a bus error count as completed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q == ST_RESP && bus.mem_resp_valid && !bus.mem_resp_err) begin
            if (is_load(op_q)) load_cnt_q  <= load_cnt_q + 32'd1;
            else               store_cnt_q <= store_cnt_q + 32'd1;
         end
         if (state_q == ST_REQ || state_q == ST_RESP) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_load_cnt  = load_cnt_q;
   assign perf_store_cnt = store_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// tb/tb_ysyx_25040105_lsu.sv - scoreboard testbench for ysyx_25040105_lsu
module tb_ysyx_25040105_lsu;
   localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                          LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

   typedef struct { logic [4:0] rd; logic [31:0] data; logic [31:0] pc; logic mis; logic err; } out_t;
   typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
   typedef struct { logic [31:0] data; logic err; } resp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ysyx_25040105_lsu_if bus();
`ifdef YSYX_25040105_LSU_PERF_EN
   logic [31:0] perf_load_cnt, perf_store_cnt, perf_stall_cnt;
`endif

   ysyx_25040105_lsu u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef YSYX_25040105_LSU_PERF_EN
      ,
      .perf_load_cnt  (perf_load_cnt),
      .perf_store_cnt (perf_store_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   out_t  out_q[$];
   req_t  req_q[$];
   resp_t resp_q[$];
   int n_checks = 0, n_pass = 0, n_req = 0;
   int req_stall_g = 0, resp_delay_g = 0, out_stall_g = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endfunction

   // Reference model: access size in bytes, 0 for non-memory ops.
   function automatic int op_size(input logic [3:0] op);
      case (op)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         LW, SW:      return 4;
         default:     return 0;
      endcase
   endfunction

   function automatic logic does_access(input logic [3:0] op, input logic [31:0] addr);
      int sz;
      sz = op_size(op);
      return (sz != 0) && ((addr % sz) == 0);
   endfunction

   function automatic out_t model_out(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] alu,
                                      input logic [4:0] rd, input logic [31:0] pc,
                                      input logic [31:0] rdata, input logic err);
      out_t o;
      int sz, off;
      logic [31:0] v;
      sz  = op_size(op);
      off = int'(addr[1:0]);
      o = '{rd: rd, data: alu, pc: pc, mis: 1'b0, err: 1'b0};
      if (sz == 0) return o;
      o.rd = 5'd0;
      o.data = 32'd0;
      if ((addr % sz) != 0) begin o.mis = 1'b1; return o; end
      if (err) begin o.err = 1'b1; return o; end
      if (op >= SB) return o;
      v = rdata >> (8 * off);
      if (sz == 1) v = v % 256;
      else if (sz == 2) v = v % 65536;
      if (op == LB && v >= 128) v = v + 32'hFFFF_FF00;
      if (op == LH && v >= 32768) v = v + 32'hFFFF_0000;
      o.rd = rd;
      o.data = v;
      return o;
   endfunction

   function automatic req_t model_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
      req_t r;
      int sz, off;
      sz  = op_size(op);
      off = int'(addr[1:0]);
      r.wen   = (op >= SB);
      r.addr  = addr & 32'hFFFF_FFFC;
      r.wdata = (sz == 1) ? (wdata % 256) * 32'h0101_0101 :
                (sz == 2) ? (wdata % 65536) * 32'h0001_0001 : wdata;
      r.wstrb = r.wen ? 4'(((1 << sz) - 1) << off) : 4'd0;
      return r;
   endfunction

   // Issue one record; optionally measure out_valid/mem_req_valid latency in cycles from acceptance.
   task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] rdata, input logic err, input int exp_lat, input bit push_out);
      resp_t rs;
      int k, req_k;
      bit acc;
      acc = does_access(op, addr);
      if (push_out) out_q.push_back(model_out(op, addr, alu, rd, pc, rdata, err));
      if (acc) begin
         req_q.push_back(model_req(op, addr, wdata));
         rs = '{data: rdata, err: err};
         resp_q.push_back(rs);
      end
      @(negedge clk);
      k = 0;
      while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
      if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_op = op; bus.in_addr = addr; bus.in_wdata = wdata;
      bus.in_alu_result = alu; bus.in_rd = rd; bus.in_pc = pc;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_op = 4'($urandom); bus.in_addr = $urandom;
      if (exp_lat > 0) begin
         req_k = 0;
         for (k = 1; k <= 30; k++) begin
            if (bus.mem_req_valid && req_k == 0) req_k = k;
            if (bus.out_valid) break;
            @(posedge clk); #1;
         end
         chk("out_latency", k, exp_lat);
         chk("req_latency", req_k, acc ? 32'd1 : 32'd0);
      end
   endtask

   // Memory model: holds ready low for req_stall_g cycles, answers after resp_delay_g cycles.
   initial begin
      resp_t rs;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data = 32'd0; bus.mem_resp_err = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.mem_req_valid) begin
            repeat (req_stall_g) @(negedge clk);
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            if (resp_q.size() == 0) rs = '{data: 32'd0, err: 1'b0};
            else rs = resp_q.pop_front();
            repeat (resp_delay_g) @(negedge clk);
            bus.mem_resp_valid = 1'b1; bus.mem_resp_data = rs.data; bus.mem_resp_err = rs.err;
            @(negedge clk);
            bus.mem_resp_valid = 1'b0; bus.mem_resp_data = $urandom; bus.mem_resp_err = 1'b0;
         end
      end
   end

   // Writeback sink: raises out_ready after out_stall_g cycles of out_valid.
   initial begin
      int cnt;
      cnt = 0;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.out_ready) begin bus.out_ready = 1'b0; cnt = 0; end
         else if (bus.out_valid) begin
            if (cnt >= out_stall_g) bus.out_ready = 1'b1;
            else cnt++;
         end
      end
   end

   // Request monitor
   initial begin
      req_t r;
      forever begin
         @(negedge clk); #1;
         if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
            n_req++;
            if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
            else begin
               r = req_q.pop_front();
               chk("req_wen", 32'(bus.mem_req_wen), 32'(r.wen));
               chk("req_addr", bus.mem_req_addr, r.addr);
               chk("req_wstrb", 32'(bus.mem_req_wstrb), 32'(r.wstrb));
               if (r.wen) chk("req_wdata", bus.mem_req_wdata, r.wdata);
            end
         end
      end
   end

   // Writeback monitor
   initial begin
      out_t e;
      forever begin
         @(negedge clk); #1;
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (out_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
               e = out_q.pop_front();
               chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
               chk("out_data", bus.out_data, e.data);
               chk("out_pc", bus.out_pc, e.pc);
               chk("out_misalign", 32'(bus.out_misalign), 32'(e.mis));
               chk("out_err", 32'(bus.out_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int reqc, outc, unstable, inrdy_bad, bad, n0;
      logic [31:0] s_addr, s_wdata, s_data;
      logic [3:0] s_wstrb;
      logic [3:0] rop;
      logic [31:0] raddr;
`ifdef YSYX_25040105_LSU_PERF_EN
      logic [31:0] stall0;
`endif
      bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_addr = 32'd0; bus.in_wdata = 32'd0;
      bus.in_alu_result = 32'd0; bus.in_rd = 5'd0; bus.in_pc = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst_out_misalign", 32'(bus.out_misalign), 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_req_addr", bus.mem_req_addr, 32'd0);
      chk("rst_req_wstrb", 32'(bus.mem_req_wstrb), 32'd0);
      rst_n = 1'b1;

      // Directed cases
      send(LW,  32'h8000_0004, 32'h1111_2222, 32'h5555_5555, 5'd5,  32'h8000_1000, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);
      send(LB,  32'h8000_0003, 32'h0,         32'h0,         5'd6,  32'h8000_1004, 32'h80FF_FFFF, 1'b0, 3, 1'b1);
      send(LBU, 32'h8000_0003, 32'h0,         32'h0,         5'd6,  32'h8000_1008, 32'h80FF_FFFF, 1'b0, 3, 1'b1);
      send(SH,  32'h8000_0002, 32'h1234_ABCD, 32'h0,         5'd7,  32'h8000_100C, 32'h0,         1'b0, 3, 1'b1);
      send(LW,  32'h8000_0001, 32'h0,         32'h0,         5'd8,  32'h8000_1010, 32'h0,         1'b0, 1, 1'b1);
      send(LH,  32'h8000_0002, 32'h0,         32'h0,         5'd9,  32'h8000_1014, 32'h8765_4321, 1'b0, 3, 1'b1);
      send(NONE,32'h0000_0013, 32'h0,         32'hCAFE_F00D, 5'd10, 32'h8000_1018, 32'h0,         1'b0, 1, 1'b1);
      send(4'd12,32'h0000_0001,32'h0,         32'h0BAD_0BAD, 5'd11, 32'h8000_101C, 32'h0,         1'b0, 1, 1'b1);
      send(LW,  32'h8000_0008, 32'h0,         32'h0,         5'd12, 32'h8000_1020, 32'h1234_5678, 1'b1, 3, 1'b1);

      // Back-pressure on both sides
      req_stall_g = 5; out_stall_g = 3;
`ifdef YSYX_25040105_LSU_PERF_EN
      stall0 = perf_stall_cnt;
`endif
      n0 = n_req;
      send(SW, 32'h8000_0010, 32'hA5A5_5A5A, 32'h0, 5'd13, 32'h8000_1024, 32'h0, 1'b0, 0, 1'b1);
      reqc = 0; outc = 0; unstable = 0; inrdy_bad = 0;
      s_addr = 32'd0; s_wdata = 32'd0; s_wstrb = 4'd0; s_data = 32'd0;
      for (int c = 0; c < 40; c++) begin
         if (!bus.out_valid && outc > 0) break;
         if (bus.in_ready) inrdy_bad++;
         if (bus.mem_req_valid) begin
            if (reqc == 0) begin s_addr = bus.mem_req_addr; s_wdata = bus.mem_req_wdata; s_wstrb = bus.mem_req_wstrb; end
            else if (s_addr != bus.mem_req_addr || s_wdata != bus.mem_req_wdata || s_wstrb != bus.mem_req_wstrb) unstable++;
            reqc++;
         end
         if (bus.out_valid) begin
            if (outc == 0) s_data = bus.out_data;
            else if (s_data != bus.out_data || bus.out_rd != 5'd0) unstable++;
            outc++;
         end
         @(posedge clk); #1;
      end
      chk("bp_req_cycles", reqc, 32'd6);
      chk("bp_out_cycles", outc, 32'd4);
      chk("bp_stable", unstable, 32'd0);
      chk("bp_in_ready_low", inrdy_bad, 32'd0);
      chk("bp_one_transfer", n_req - n0, 32'd1);
`ifdef YSYX_25040105_LSU_PERF_EN
      chk("perf_stall_ge6", 32'(perf_stall_cnt - stall0 >= 32'd6), 32'd1);
`endif
      req_stall_g = 0; out_stall_g = 0;

      // Reset while waiting for a response; the late response must be ignored.
      resp_delay_g = 4;
      send(LW, 32'h8000_0020, 32'h0, 32'h0, 5'd14, 32'h8000_1028, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.out_valid || bus.mem_req_valid) bad++;
         @(posedge clk); #1;
      end
      chk("rst_mid_quiet", bad, 32'd0);
      chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      resp_delay_g = 0;
      send(LW, 32'h8000_0024, 32'h0, 32'h0, 5'd15, 32'h8000_102C, 32'h0102_0304, 1'b0, 3, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         req_stall_g  = int'($urandom_range(0, 3));
         resp_delay_g = int'($urandom_range(0, 3));
         out_stall_g  = int'($urandom_range(0, 3));
         rop   = 4'($urandom_range(0, 15));
         raddr = 32'h8000_0000 + $urandom_range(0, 255);
         send(rop, raddr, $urandom, $urandom, 5'($urandom), $urandom & 32'hFFFF_FFFC,
              $urandom, ($urandom_range(0, 7) == 0), 0, 1'b1);
      end

      begin
         int k;
         k = 0;
         while ((out_q.size() != 0 || req_q.size() != 0) && k < 2000) begin @(posedge clk); k++; end
      end
      chk("drain_out", out_q.size(), 32'd0);
      chk("drain_req", req_q.size(), 32'd0);
      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ysyx_25040105_lsu.md
Name: ysyx_25040105_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Latches one execute result per transaction: op, effective address, store data, rd, pc and ALU result.
- Performs at most one memory access over a valid/ready request/response bus, then hands one writeback record to the WBU.
- Replaces direct DPI memory access in execute with a real multi-cycle handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute record valid
- in_ready  out  1  LSU can accept a record
- in_op  in  4  memory op: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8
- in_addr  in  32  effective address (rs1+imm)
- in_wdata  in  32  store data (rs2)
- in_alu_result  in  32  pass-through result for op NONE
- in_rd  in  5  destination register
- in_pc  in  32  instruction pc
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_wen  out  1  1=write, 0=read
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  32  lane-aligned store data
- mem_req_wstrb  out  4  byte enables; 0 for reads
- mem_resp_valid  in  1  response valid, single-cycle pulse
- mem_resp_data  in  32  read word
- mem_resp_err  in  1  bus error
- out_valid  out  1  writeback record valid
- out_ready  in  1  WBU accepts the record
- out_rd  out  5  destination register; 0 for stores and faults
- out_data  out  32  writeback data
- out_pc  out  32  pc of the completed instruction
- out_misalign  out  1  misaligned access fault
- out_err  out  1  bus error fault

Behaviour:
- Clock and reset: single clock. rst_n asynchronous, active-low.
- Reset values: state=IDLE; mem_req_valid=0, out_valid=0, out_misalign=0, out_err=0; all latched data, address and strobe registers = 0. in_ready=1 after reset.
- FSM states: IDLE, REQ, RESP, OUT.
- IDLE:
  - in_ready=1; in_ready is 0 in every other state.
  - On in_valid&&in_ready, latch all in_* fields.
  - op NONE -> OUT, with out_data=in_alu_result.
  - Misaligned access -> OUT, with out_misalign=1, out_rd=0, out_data=0, and no bus access. Misaligned means half-word op with addr[0]=1, or word op with addr[1:0]!=0.
  - Otherwise -> REQ.
- REQ:
  - mem_req_valid=1; all mem_req_* are registered and held stable until mem_req_ready.
  - On mem_req_valid&&mem_req_ready -> RESP.
- RESP:
  - Wait for mem_resp_valid; -> OUT on its arrival. A response never arrives in the same cycle as the request handshake.
  - Load: out_data = lane extract of mem_resp_data >> (addr[1:0]*8), sign-extended (LB, LH) or zero-extended (LBU, LHU, LW).
  - Store: out_data=0, out_rd=0.
  - mem_resp_err=1: out_err=1, out_data=0, out_rd=0.
- OUT:
  - out_valid=1, with all out_* held until out_ready; on handshake -> IDLE.
  - No bypass: the next record is accepted one cycle after the out handshake.
- Store lanes:
  - wdata replicated: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - wstrb: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111, where off=addr[1:0].
- Latency, in_valid accepted at cycle T:
  - NONE or misaligned: out_valid at T+1.
  - Memory op: mem_req_valid at T+1 and, with immediate ready and a next-cycle response, out_valid at T+3.
- Back-pressure:
  - out_ready=0 holds OUT indefinitely.
  - mem_req_ready=0 holds REQ indefinitely.
- Reset mid-transaction: immediate return to IDLE with no outputs asserted; an outstanding bus response arriving after reset is ignored in IDLE.
- mem_resp_valid outside RESP is ignored.
- Illegal in_op (9..15) is treated as NONE.

Optional Feature:
- Macro: YSYX_25040105_LSU_PERF_EN.
- Defined: adds three outputs, each 32 bits and wrapping, reset to 0:
  - perf_load_cnt: +1 per completed load.
  - perf_store_cnt: +1 per completed store.
  - perf_stall_cnt: +1 per cycle in REQ or RESP.
  - Faulted accesses are not counted.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package ysyx_25040105_lsu_pkg holds:
  - in_op encoding constants;
  - FSM state enum (2 bits);
  - functions: wstrb generation, misalign check, is_load/is_store.
- One combinational sub-module, ysyx_25040105_lsu_align: load lane extract with sign/zero extend, and store lane replication.

Test Plan:
- LW addr=0x80000004, resp data=0xDEADBEEF, ready and response immediate -> mem_req_addr=0x80000004, wstrb=0, out_data=0xDEADBEEF, out_valid at T+3.
- LB addr=0x80000003, resp=0x80FF_FFFF -> out_data=0xFFFFFF80. LBU at the same address -> out_data=0x00000080.
- SH addr=0x80000002, wdata=0x1234ABCD -> wdata=0xABCDABCD, wstrb=4'b1100, wen=1, out_rd=0.
- LW addr=0x80000001 -> no mem_req_valid, out_misalign=1 at T+1. LH addr=...2 is legal.
- mem_req_ready low for 5 cycles, then out_ready low for 3 cycles -> all req and out fields stable, in_ready=0 throughout, exactly one transfer. With the perf feature defined: stall_cnt >= 6.
- rst_n asserted while in RESP, and a late mem_resp_valid follows -> IDLE, out_valid never rises, next LW completes normally. With mem_resp_err=1 -> out_err=1, out_data=0.
